// File: rtl/galetron_pkg.sv
// Shared definitions for the Galetron instruction path.
//   GT_ADDR_W / GT_DATA_W : default address and word widths
//   boot_state_t          : boot sequencer states
//   NOP_WORD              : canonical no-op instruction word
package galetron_pkg;

  localparam int unsigned GT_ADDR_W = 10;
  localparam int unsigned GT_DATA_W = 32;

  typedef enum logic [1:0] {
    WAIT = 2'd0,  // one settle cycle so BIOS contents are valid
    COPY = 2'd1,  // one BIOS word written to imem per cycle
    DONE = 2'd2   // copy complete, CPU owns imem addressing
  } boot_state_t;

  localparam logic [GT_DATA_W-1:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/boot_controller.sv
// Post-reset boot sequencer. Copies BIOS_DEPTH words from the BIOS ROM
// into instruction memory (one per clock) while the CPU is halted, then
// hands imem addressing to the CPU fetch port. A start pulse in DONE reruns
// the copy without a full reset.
// Ports:
//   clock, reset  : clock and asynchronous active-high reset
//   start         : re-boot request (honoured only in DONE)
//   bios_address  : BIOS read address (out)
//   bios_data     : BIOS word, combinational in bios_address (in)
//   cpu_address   : CPU instruction-fetch address (in)
//   imem_address  : instruction-memory address (out)
//   imem_data     : instruction-memory write data (out)
//   imem_write    : instruction-memory write enable (out)
//   cpu_halt      : CPU stall, high until a copy completes (out)
//   boot_done     : high once a copy has completed (out)
//   checksum      : running XOR of words written in the current copy (out)
module boot_controller
  import galetron_pkg::*;
#(
  parameter int unsigned BIOS_DEPTH = 32,
  parameter logic [9:0]  START_ADDR = 10'h000,
  parameter int unsigned ADDR_W     = GT_ADDR_W,
  parameter int unsigned DATA_W     = GT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] bios_address,
  input  logic [DATA_W-1:0] bios_data,
  input  logic [ADDR_W-1:0] cpu_address,
  output logic [ADDR_W-1:0] imem_address,
  output logic [DATA_W-1:0] imem_data,
  output logic              imem_write,
  output logic              cpu_halt,
  output logic              boot_done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(BIOS_DEPTH - 1);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  boot_state_t       r_state;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_checksum;
  logic [ADDR_W-1:0] w_copy_addr;

  // Destination address wraps modulo 2^ADDR_W.
  assign w_copy_addr = ADDR_W'(START_ADDR) + r_count[ADDR_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= WAIT;
      r_count    <= '0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        WAIT: r_state <= COPY;
        COPY: begin
          r_checksum <= r_checksum ^ bios_data;
          r_count    <= r_count + ONE;
          if (r_count == LAST_IDX) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (start) begin
            r_state    <= WAIT;
            r_count    <= '0;
            r_checksum <= '0;
          end
        end
        default: r_state <= WAIT;
      endcase
    end
  end

  // imem mux: copy engine drives the port in WAIT/COPY, CPU only in DONE.
  always_comb begin
    bios_address = '0;
    imem_address = w_copy_addr;
    imem_data    = '0;
    imem_write   = 1'b0;
    case (r_state)
      COPY: begin
        bios_address = r_count[ADDR_W-1:0];
        imem_data    = bios_data;
        imem_write   = 1'b1;
      end
      DONE:    imem_address = cpu_address;
      default: ;
    endcase
  end

  // Status flags are pure decodes of the state register.
  assign cpu_halt  = (r_state != DONE);
  assign boot_done = (r_state == DONE);
  assign checksum  = r_checksum;

endmodule

// File: tb/tb_boot_controller.sv
module tb_boot_controller;

  localparam int NI = 3;
  localparam logic [9:0] SA [NI] = '{10'h010, 10'h3FE, 10'h005};
  localparam int DEPTH [NI] = '{4, 4, 1};

  typedef struct {
    int          id;
    int          idx;
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        start [NI];
  logic [9:0]  cpu_a;
  logic [9:0]  bios_a [NI];
  logic [31:0] bios_d [NI];
  logic [9:0]  imem_a [NI];
  logic [31:0] imem_d [NI];
  logic        wr   [NI];
  logic        halt [NI];
  logic        done [NI];
  logic [31:0] csum [NI];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] bios_word(input int id, input logic [9:0] a);
    return (32'(id + 1) << 28) ^ (32'(a) * 32'h0001_0101) ^ 32'h5A5A_0000;
  endfunction

  always_comb begin
    for (int i = 0; i < NI; i++) bios_d[i] = bios_word(i, bios_a[i]);
  end

  boot_controller #(.BIOS_DEPTH(4), .START_ADDR(10'h010), .ADDR_W(10), .DATA_W(32)) u_basic (
    .clock(clk), .reset(rst[0]), .start(start[0]), .bios_address(bios_a[0]),
    .bios_data(bios_d[0]), .cpu_address(cpu_a), .imem_address(imem_a[0]),
    .imem_data(imem_d[0]), .imem_write(wr[0]), .cpu_halt(halt[0]),
    .boot_done(done[0]), .checksum(csum[0]));

  boot_controller #(.BIOS_DEPTH(4), .START_ADDR(10'h3FE), .ADDR_W(10), .DATA_W(32)) u_wrap (
    .clock(clk), .reset(rst[1]), .start(start[1]), .bios_address(bios_a[1]),
    .bios_data(bios_d[1]), .cpu_address(cpu_a), .imem_address(imem_a[1]),
    .imem_data(imem_d[1]), .imem_write(wr[1]), .cpu_halt(halt[1]),
    .boot_done(done[1]), .checksum(csum[1]));

  boot_controller #(.BIOS_DEPTH(1), .START_ADDR(10'h005), .ADDR_W(10), .DATA_W(32)) u_one (
    .clock(clk), .reset(rst[2]), .start(start[2]), .bios_address(bios_a[2]),
    .bios_data(bios_d[2]), .cpu_address(cpu_a), .imem_address(imem_a[2]),
    .imem_data(imem_d[2]), .imem_write(wr[2]), .cpu_halt(halt[2]),
    .boot_done(done[2]), .checksum(csum[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected writes for words 0..n-1; returns their XOR.
  task automatic push_copy(input int id, input int n, output logic [31:0] cs);
    exp_t e;
    cs = '0;
    for (int k = 0; k < n; k++) begin
      e.id   = id;
      e.idx  = k;
      e.addr = SA[id] + 10'(k);
      e.data = bios_word(id, 10'(k));
      cs     = cs ^ e.data;
      sb.push_back(e);
    end
  endtask

  // Every presented write is popped against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (wr[i] === 1'b1) begin
        chk("wr_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_inst",   i,               e.id);
          chk("bios_addr", 32'(bios_a[i]),  32'(e.idx));
          chk("imem_addr", 32'(imem_a[i]),  32'(e.addr));
          chk("imem_data", imem_d[i],       e.data);
        end
      end
    end
  end

  task automatic chk_reset_state(input int id);
    chk("rst_halt", 32'(halt[id]),   32'd1);
    chk("rst_done", 32'(done[id]),   32'd0);
    chk("rst_wr",   32'(wr[id]),     32'd0);
    chk("rst_baddr", 32'(bios_a[id]), 32'd0);
    chk("rst_csum", csum[id],        32'd0);
  endtask

  // Entered just after negedge with the DUT about to leave WAIT on the next edge.
  task automatic run_copy(input int id, input int pulse_at);
    logic [31:0] cs;
    int n;
    n = DEPTH[id];
    push_copy(id, n, cs);
    for (int e = 1; e <= n + 1; e++) begin
      @(negedge clk);
      if (e <= n) begin
        chk("busy_halt", 32'(halt[id]), 32'd1);
        chk("busy_done", 32'(done[id]), 32'd0);
        chk("busy_wr",   32'(wr[id]),   32'd1);
      end else begin
        chk("fin_done", 32'(done[id]), 32'd1);
        chk("fin_halt", 32'(halt[id]), 32'd0);
        chk("fin_wr",   32'(wr[id]),   32'd0);
        chk("fin_csum", csum[id],      cs);
      end
      if (pulse_at == e) begin
        #1 start[id] = 1'b1;
      end else if (start[id]) begin
        #1 start[id] = 1'b0;
      end
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic boot_from_reset(input int id, input int pulse_at);
    #1 rst[id] = 1'b0;
    run_copy(id, pulse_at);
  endtask

  task automatic reboot(input int id);
    #1 start[id] = 1'b1;
    @(negedge clk);
    chk("rb_halt", 32'(halt[id]), 32'd1);
    chk("rb_done", 32'(done[id]), 32'd0);
    chk("rb_wr",   32'(wr[id]),   32'd0);
    chk("rb_csum", csum[id],      32'd0);
    #1 start[id] = 1'b0;
    run_copy(id, 0);
  endtask

  task automatic passthrough(input int id, input logic [9:0] a);
    #1 cpu_a = a;
    #1;
    chk("pt_addr", 32'(imem_a[id]), 32'(a));
    chk("pt_wr",   32'(wr[id]),     32'd0);
    chk("pt_data", imem_d[id],      32'd0);
  endtask

  task automatic reset_mid_copy(input int id);
    logic [31:0] cs;
    #1 rst[id] = 1'b1;
    @(negedge clk);
    chk_reset_state(id);
    #1 rst[id] = 1'b0;
    push_copy(id, 3, cs);
    repeat (3) @(negedge clk);
    chk("mid_csum", csum[id], bios_word(id, 10'd0) ^ bios_word(id, 10'd1));
    #1 rst[id] = 1'b1;
    #1;
    chk_reset_state(id);
    chk("mid_sb", 32'(sb.size()), 32'd0);
    @(negedge clk);
    boot_from_reset(id, 0);
  endtask

  initial begin
    cpu_a = '0;
    for (int i = 0; i < NI; i++) begin
      rst[i]   = 1'b1;
      start[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) chk_reset_state(i);

    boot_from_reset(0, 2);       // start pulse during COPY must be ignored
    reboot(0);
    passthrough(0, 10'h055);
    passthrough(0, 10'h3FF);
    @(negedge clk);
    reset_mid_copy(0);

    @(negedge clk);
    boot_from_reset(1, 0);       // destination address wraps past 0x3FF
    passthrough(1, 10'h123);
    @(negedge clk);
    boot_from_reset(2, 0);       // single-word copy

    @(negedge clk);
    chk("final_sb", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
